// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants: instruction ROM geometry and fetch reset address.
// The instruction ROM and the fetch unit both take their defaults from here.
package fetch_unit_pkg;

    localparam int CPU_ADDR_W   = 10;
    localparam int CPU_INSTR_W  = 32;
    localparam int CPU_RESET_PC = 0;

    localparam int BUF_DEPTH    = 2;

    typedef logic [1:0] buf_count_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: dual-port ROM read side, decode-facing pair handshake, redirect.
// The fetch unit is the master; ROM, decode and branch logic together form the slave.
interface fetch_unit_if import fetch_unit_pkg::*; #(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int INSTR_W = CPU_INSTR_W
);

    logic [ADDR_W-1:0]  rom_addr1;
    logic [ADDR_W-1:0]  rom_addr2;
    logic [INSTR_W-1:0] rom_instr1;
    logic [INSTR_W-1:0] rom_instr2;

    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr1;
    logic [INSTR_W-1:0] out_instr2;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output rom_addr1, rom_addr2,
        input  rom_instr1, rom_instr2,
        output out_valid, out_pc, out_instr1, out_instr2,
        input  out_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_addr1, rom_addr2,
        output rom_instr1, rom_instr2,
        input  out_valid, out_pc, out_instr1, out_instr2,
        output out_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_unit_buf.sv
// Two-entry FIFO holding fetched {pc, instr1, instr2} pairs.
// Flush takes priority over push and pop in the same cycle.
module fetch_buf import fetch_unit_pkg::*; #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] tail_data,
    output logic [DATA_W-1:0] head_data,
    output buf_count_t        count
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    buf_count_t        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != buf_count_t'(BUF_DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = tail_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + buf_count_t'(do_push) - buf_count_t'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues paired ROM reads (pc, pc+1) and streams them to decode
// through a two-entry buffer, with flush-and-restart on redirect.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int RESET_PC = CPU_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int ENTRY_W = ADDR_W + 2 * INSTR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic               pop, push, issue;
    logic [2:0]         occupancy;
    buf_count_t         count;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] tail;

    // Occupancy counts the slot already promised to the in-flight read, so the
    // buffer can never be asked to hold a third pair.
    always_comb begin
        pop           = bus.out_valid && bus.out_ready;
        occupancy     = 3'(count) + 3'(inflight_q) - 3'(pop);
        issue         = !bus.redirect_valid && (occupancy < 3'd2);
        push          = inflight_q && !bus.redirect_valid;
        tail          = {inflight_pc_q, bus.rom_instr1, bus.rom_instr2};
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(2);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buf #(
        .DATA_W (ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .tail_data (tail),
        .head_data (head),
        .count     (count)
    );

    assign bus.rom_addr1  = pc_q;
    assign bus.rom_addr2  = pc_q + ADDR_W'(1);
    assign bus.out_valid  = (count != '0);
    assign bus.out_pc     = head[ENTRY_W-1 -: ADDR_W];
    assign bus.out_instr1 = head[2*INSTR_W-1 -: INSTR_W];
    assign bus.out_instr2 = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous ROM model, stream model of expected pairs,
// per-cycle compare plus directed literal checks.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 10;
    localparam int IW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .RESET_PC (0)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    // Synchronous ROM: data appears one clock after the address is sampled.
    always @(posedge clk) begin
        bus.rom_instr1 <= rom_word(bus.rom_addr1);
        bus.rom_instr2 <= rom_word(bus.rom_addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: the next pair owed to decode, and edges since the last restart.
    logic [AW-1:0] exp_pc = '0;
    int            since  = 0;

    always @(negedge clk) begin
        logic [AW-1:0] nxt;
        if (!rst_n) begin
            since  = 0;
            exp_pc = '0;
        end
        chk("model_valid", 32'(bus.out_valid), 32'(since >= 2));
        if (bus.out_valid) begin
            nxt = exp_pc + 10'd1;
            chk("model_pc", 32'(bus.out_pc), 32'(exp_pc));
            chk("model_instr1", bus.out_instr1, rom_word(exp_pc));
            chk("model_instr2", bus.out_instr2, rom_word(nxt));
        end
        chk("occupancy_le2", 32'((int'(u_dut.count) + int'(u_dut.inflight_q)) <= 2), 32'd1);
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) exp_pc = exp_pc + 10'd2;
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
                since  = 0;
            end else if (since < 3) begin
                since++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat;

    initial begin
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        pat                = 32'b1011_0010_1110_0101_1100_0110_1011_0011;

        repeat (3) step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_instr1", bus.out_instr1, 32'd0);
        chk("rst_instr2", bus.out_instr2, 32'd0);
        chk("rst_addr1", 32'(bus.rom_addr1), 32'd0);
        chk("rst_addr2", 32'(bus.rom_addr2), 32'd1);

        rst_n = 1'b1;
        step();
        chk("edge1_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("edge2_valid", 32'(bus.out_valid), 32'd1);
        chk("edge2_pc", 32'(bus.out_pc), 32'd0);
        chk("edge2_instr1", bus.out_instr1, 32'h1000_0000);
        chk("edge2_instr2", bus.out_instr2, 32'h1000_0001);
        step();
        chk("stream_pc2", 32'(bus.out_pc), 32'd2);
        step();
        chk("stream_pc4", 32'(bus.out_pc), 32'd4);

        bus.out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_hold_pc", 32'(bus.out_pc), 32'd4);
        end
        bus.out_ready = 1'b1;
        step();
        chk("resume_pc", 32'(bus.out_pc), 32'd6);

        for (int i = 0; i < 8 && bus.out_pc != 10'd8; i++) step();
        chk("reach_pc8", 32'(bus.out_pc), 32'd8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h100;
        step();
        bus.redirect_valid = 1'b0;
        chk("hs_redir_flush", 32'(bus.out_valid), 32'd0);
        step();
        chk("hs_redir_gap", 32'(bus.out_valid), 32'd0);
        step();
        chk("hs_redir_valid", 32'(bus.out_valid), 32'd1);
        chk("hs_redir_pc", 32'(bus.out_pc), 32'h100);
        step();
        chk("hs_redir_next", 32'(bus.out_pc), 32'h102);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h3FF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr1", 32'(bus.rom_addr1), 32'h3FF);
        chk("wrap_addr2", 32'(bus.rom_addr2), 32'h000);
        step();
        step();
        chk("wrap_pc", 32'(bus.out_pc), 32'h3FF);
        chk("wrap_instr1", bus.out_instr1, 32'h1000_03FF);
        chk("wrap_instr2", bus.out_instr2, 32'h1000_0000);
        step();
        chk("wrap_next_pc", 32'(bus.out_pc), 32'h001);
        chk("wrap_next_instr1", bus.out_instr1, 32'h1000_0001);

        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("full_count", 32'(u_dut.count), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h040;
        step();
        bus.redirect_valid = 1'b0;
        chk("full_redir_flush", 32'(bus.out_valid), 32'd0);
        step();
        chk("full_redir_gap", 32'(bus.out_valid), 32'd0);
        step();
        chk("full_redir_pc", 32'(bus.out_pc), 32'h040);
        step();
        chk("full_redir_hold", 32'(bus.out_pc), 32'h040);
        bus.out_ready = 1'b1;
        step();
        chk("full_redir_next", 32'(bus.out_pc), 32'h042);

        for (int i = 0; i < 32; i++) begin
            bus.out_ready      = pat[i];
            bus.redirect_valid = (i == 20);
            bus.redirect_pc    = 10'h3FE;
            step();
        end
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        repeat (3) step();

        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_pc", 32'(bus.out_pc), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("restart_edge1", 32'(bus.out_valid), 32'd0);
        step();
        chk("restart_valid", 32'(bus.out_valid), 32'd1);
        chk("restart_pc", 32'(bus.out_pc), 32'd0);
        step();
        chk("restart_pc2", 32'(bus.out_pc), 32'd2);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
